ram_dual_client_master: RTL
===========================

# ram_dual_client_master

Initiator-side controller for the team's 64x8 dual-address single-write RAM with chip-select port steering. It accepts burst read and write requests from two clients, arbitrates between them round-robin, and drives the RAM's `Data0/Addr0` or `Data1/Addr1` lanes together with `we` and `CS`. It also captures read data from the RAM's tri-stated `Y` output and returns it to the requesting client with a valid strobe. Client 0 always uses RAM port 0 (`CS=1`); client 1 always uses RAM port 1 (`CS=0`).

## Interface
- `AW`, default 6: RAM address width; addresses wrap modulo 2^AW.
- `DW`, default 8: data width.
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `ReqValid0`/`ReqValid1` in 1: a client request is pending.
- `ReqReady0`/`ReqReady1` out 1: request accepted this cycle (combinational, only in IDLE).
- `ReqWe0`/`ReqWe1` in 1: 1 = write burst, 0 = read burst.
- `ReqAddr0`/`ReqAddr1` in AW: burst base address.
- `ReqLen0`/`ReqLen1` in AW: number of beats minus 1 (0..63).
- `WrValid0`/`WrValid1` in 1: a write beat is available.
- `WrData0`/`WrData1` in DW: write beat data.
- `WrReady0`/`WrReady1` out 1: write beat consumed this cycle (combinational).
- `RdData` out DW: read beat data, driven combinationally from `MemY`.
- `RdValid0`/`RdValid1` out 1: `RdData` is valid for that client (registered).
- `Busy` out 1: the FSM is not in IDLE.
- `MemData0`/`MemData1` out DW: RAM write-data lanes.
- `MemAddr0`/`MemAddr1` out AW: RAM address lanes.
- `MemWe` out 1: RAM write enable.
- `MemCS` out 1: RAM port select (1 = port 0, 0 = port 1).
- `MemY` in DW: RAM read output. `MemY` is valid only while `MemWe=0`.

## Operation
- **FSM states:** IDLE, WRITE, READ, DRAIN.
- **IDLE**
  - Grant goes to the single valid client.
  - If both clients are valid, grant goes to the client not served last. The round-robin pointer resets to favour client 0.
  - `ReqReady` is asserted for the granted client only.
  - On the handshake the controller latches client ID, base address, length, and direction. It clears the beat counter.
  - It then moves to WRITE or READ.
- **WRITE**
  - Each cycle, if `WrValid` is high for the owner: `MemWe=1`, `WrReady=1`, address = base+beat (mod 2^AW), `MemData*` = `WrData`.
  - The beat counter increments on each accepted beat.
  - If `WrValid` is low, the controller stalls with `MemWe=0`. This is a harmless read.
  - After beat `ReqLen` is accepted, the FSM returns to IDLE.
- **READ**
  - Each cycle the controller issues address = base+beat with `MemWe=0`, one beat per cycle, no stalls.
  - After the final issue it moves to DRAIN.
- **DRAIN**
  - Lasts one cycle with `MemWe=0`, so the last beat can be captured.
  - Then returns to IDLE.
- **Read return:** `RdValid<owner>` is the issue strobe delayed by one register stage. `RdData` = `MemY`.
- **Lane driving:**
  - `MemCS` = owner==0.
  - The non-owned lane's `MemAddr` and `MemData` are driven to 0.
  - In IDLE, `MemWe=0`, `MemCS` holds its last value, and all lanes are 0.
- **Round-robin pointer:** updates on each grant to "last served = granted client".

## Timing
- **Reset:** while `Rst` is high, all registered outputs clear at the edge:
  - `MemWe=0`, `MemCS=1`, lanes 0.
  - `RdValid*` 0, `Busy` 0.
  - FSM goes to IDLE and the pointer favours client 0.
  - `ReqReady*` and `WrReady*` are forced to 0 during reset.
- **Reset mid-burst:** the burst is abandoned. No further `WrReady`/`RdValid` pulses occur, including any pending drain capture.
- **Request to first beat:** a handshake in cycle t puts the first RAM access in cycle t+1.
- **Read latency:** an address issued in cycle t gives `RdValid` and `RdData` (= M[addr]) in cycle t+1.
  - An N-beat read occupies N+1 cycles after acceptance.
  - Beats are returned in order, with no gaps.
- **Write burst length:** an N-beat write with `WrValid` held high occupies N cycles. The RAM is updated at the end of each beat cycle.
- **Wrap-around:** base+beat overflows modulo 2^AW. For example, base 62 with len 3 gives addresses 62, 63, 0, 1.
- **Back-to-back requests:** IDLE lasts at least 1 cycle between bursts, so there is no request overlap.
- **Simultaneous requests:** `ReqValid0` and `ReqValid1` high in the same IDLE cycle are served alternately.
- **Same-address write-then-read:** ordering follows acceptance order, so a read after a write sees the written data.

## Test plan
- **Reset:** assert `Rst` 2 cycles with random inputs → `MemWe=0`, `MemCS=1`, `Busy=0`, all ready/valid outputs 0.
- **Client 0 write:** write burst addr 5, len 3, data 0xA0..0xA3 → `MemWe=1`, `MemCS=1`, `MemAddr0`=5..8 on 4 consecutive cycles. Then a client 0 read of addr 5, len 3 → `RdValid0` for 4 consecutive cycles with data 0xA0..0xA3, starting 2 cycles after the handshake.
- **Client 1 wrapped write/read:** write addr 62, len 3, data 0x11..0x14 → `MemCS=0`, `MemAddr1`=62, 63, 0, 1. Readback returns 0x11..0x14 on `RdValid1`.
- **Contention:** both clients request every IDLE for 4 requests → grants in order 0, 1, 0, 1. After a mid-sequence reset the next tie goes to client 0.
- **Write stall:** `WrValid0` low for 2 cycles mid-burst → `MemWe=0` during the stall, no address advance, and all beats are stored exactly once.
- **Reset during read:** assert `Rst` at beat 2 of a len-7 read → no `RdValid` after the reset edge, and the FSM is in IDLE with `Busy=0` the next cycle.

Source files
------------

// File: rtl/ram_dual_client_master.sv
// Two-client burst controller for the 64x8 dual-address RAM: round-robin grant,
// chip-select lane steering, and one-cycle-latency read return.
module ram_dual_client_master #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          ReqValid0,
    input  logic          ReqValid1,
    output logic          ReqReady0,
    output logic          ReqReady1,
    input  logic          ReqWe0,
    input  logic          ReqWe1,
    input  logic [AW-1:0] ReqAddr0,
    input  logic [AW-1:0] ReqAddr1,
    input  logic [AW-1:0] ReqLen0,
    input  logic [AW-1:0] ReqLen1,
    input  logic          WrValid0,
    input  logic          WrValid1,
    input  logic [DW-1:0] WrData0,
    input  logic [DW-1:0] WrData1,
    output logic          WrReady0,
    output logic          WrReady1,
    output logic [DW-1:0] RdData,
    output logic          RdValid0,
    output logic          RdValid1,
    output logic          Busy,
    output logic [DW-1:0] MemData0,
    output logic [DW-1:0] MemData1,
    output logic [AW-1:0] MemAddr0,
    output logic [AW-1:0] MemAddr1,
    output logic          MemWe,
    output logic          MemCS,
    input  logic [DW-1:0] MemY
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          cs_q, cs_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] beat_q, beat_d;
    logic [1:0]    rdv_q, rdv_d;

    logic          gnt;
    logic          wv;
    logic          issue;
    logic          active;
    logic          wr_beat;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    // On a tie the client not served last wins; last_q resets to 1 so client 0 wins first.
    always_comb begin
        if (ReqValid0 && ReqValid1) gnt = ~last_q;
        else                        gnt = ReqValid1;
    end

    assign addr  = base_q + beat_q;
    assign wv    = owner_q ? WrValid1 : WrValid0;
    assign wdata = owner_q ? WrData1 : WrData0;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cs_d      = cs_q;
        base_d    = base_q;
        len_d     = len_q;
        beat_d    = beat_q;
        ReqReady0 = 1'b0;
        ReqReady1 = 1'b0;
        WrReady0  = 1'b0;
        WrReady1  = 1'b0;
        wr_beat   = 1'b0;
        issue     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((ReqValid0 || ReqValid1) && !Rst) begin
                    ReqReady0 = ~gnt;
                    ReqReady1 = gnt;
                    owner_d   = gnt;
                    last_d    = gnt;
                    cs_d      = ~gnt;
                    base_d    = gnt ? ReqAddr1 : ReqAddr0;
                    len_d     = gnt ? ReqLen1 : ReqLen0;
                    beat_d    = '0;
                    state_d   = (gnt ? ReqWe1 : ReqWe0) ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                // A missing write beat leaves the RAM in a harmless read of the same address.
                if (wv && !Rst) begin
                    wr_beat  = 1'b1;
                    WrReady0 = ~owner_q;
                    WrReady1 = owner_q;
                    beat_d   = beat_q + AW'(1);
                    if (beat_q == len_q) state_d = S_IDLE;
                end
            end
            S_READ: begin
                issue  = 1'b1;
                beat_d = beat_q + AW'(1);
                if (beat_q == len_q) state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
        rdv_d = {issue & owner_q, issue & ~owner_q};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cs_q    <= 1'b1;
            beat_q  <= '0;
            rdv_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            beat_q  <= beat_d;
            rdv_q   <= rdv_d;
        end
    end

    always_ff @(posedge Clk) begin
        base_q <= base_d;
        len_q  <= len_d;
    end

    assign active   = (state_q == S_WRITE) || (state_q == S_READ);
    assign MemWe    = wr_beat;
    assign MemCS    = cs_q;
    assign MemAddr0 = (active && !owner_q) ? addr : '0;
    assign MemAddr1 = (active && owner_q) ? addr : '0;
    assign MemData0 = (wr_beat && !owner_q) ? wdata : '0;
    assign MemData1 = (wr_beat && owner_q) ? wdata : '0;
    assign RdData   = MemY;
    assign RdValid0 = rdv_q[0];
    assign RdValid1 = rdv_q[1];
    assign Busy     = (state_q != S_IDLE);

endmodule
